register_selector: RTL and testbench
====================================

Name: register_selector

Overview:
- Consumes the register-select event stream (is_reg pulse plus 3-bit reg_num) produced by the register-button decoder.
- Sequences operand selection for one matrix operation: source A, optional source B, then destination.
- Presents latched operand numbers and a one-hot register LED image (the inverse mapping of the button decoder) to the datapath and display.
- Sits between the button front end and the operation controller.

Parameters:
TIMEOUT, 1000000, clocks of inactivity in any GET_* state before the sequence aborts
TCNT_W, 20, width of the timeout counter; must satisfy 2**TCNT_W > TIMEOUT

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
is_reg  input  1  one-cycle pulse: a register button was pressed
reg_num  input  3  register number 1..4; valid in the cycle after is_reg; 0 = invalid/multi-press
op_start  input  1  one-cycle pulse: begin selection for a new operation
op_unary  input  1  sampled with op_start; 1 = single-source op, skip source B
cancel  input  1  level; aborts the sequence
src_a  output  3  latched source A register number
src_b  output  3  latched source B register number; 0 for unary ops
dest  output  3  latched destination register number
reg_led  output  4  one-hot OR of registers selected in the current or last sequence
busy  output  1  high in GET_A, GET_B and GET_D
sel_valid  output  1  one-cycle pulse: src_a, src_b and dest are complete
timeout  output  1  one-cycle pulse: sequence aborted on inactivity
state  output  3  current FSM state code, for debug and display

Behaviour:
- Interface: one clock clk; reset nrst is asynchronous and active-low. All state is reset by nrst low and is otherwise updated on the rising edge of clk.
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0; internal is_reg delay flop 0.
- Event capture: is_reg is delayed one cycle (is_reg_d). reg_num is sampled when is_reg_d=1. A sample with reg_num=0 or reg_num>4 is ignored: no state change, no counter reload.
- State codes: IDLE=0, GET_A=1, GET_B=2, GET_D=3, DONE=4.
- IDLE:
  - op_start=1 -> GET_A.
  - On that transition: clear src_a, src_b, dest and reg_led; latch op_unary internally; load timeout counter to 0.
  - is_reg events in IDLE are ignored.
- GET_A: a valid event latches src_a and sets reg_led bit (reg_num-1). Next state is GET_D if unary, else GET_B.
- GET_B: a valid event latches src_b and sets its LED bit -> GET_D.
- GET_D: a valid event latches dest and sets its LED bit -> DONE. dest may equal either source.
- DONE: lasts exactly one cycle with sel_valid=1 -> IDLE. Latched values and reg_led hold until the next op_start, cancel or timeout.
- busy is combinational from state.
- Latency: sel_valid asserts 2 cycles after the is_reg pulse that carries the destination selection.
- Timeout counter:
  - Increments every cycle in GET_A, GET_B and GET_D.
  - Clears on each accepted event and on each state change.
  - When the count reaches TIMEOUT-1 with no event that cycle: go to IDLE, pulse timeout, clear src_a, src_b, dest and reg_led.
- cancel=1 in any state: next state IDLE; clear src_a, src_b, dest and reg_led; no sel_valid, no timeout pulse.
- Priority within one cycle: cancel > accepted event > timeout.
- op_start outside IDLE is ignored; it neither restarts nor aborts.
- op_start and a sampled event in the same IDLE cycle: the event is dropped and the FSM moves to GET_A.
- Reset asserted mid-sequence: immediate return to reset values; no sel_valid.
- Illegal state codes recover to IDLE on the next clock.

Optional Feature:
- Macro: REG_SELECTOR_DUP_REJECT_EN.
- Defined: in GET_B, an event with reg_num equal to src_a is rejected.
  - State, src_b and reg_led are unchanged.
  - The timeout counter still clears.
  - Adds output dup_err (1 bit), which pulses for one cycle on the rejection, reset 0.
- Undefined: duplicates are accepted normally; the dup_err port does not exist.

Test Plan:
- Reset held, then released -> all outputs 0, state=0; is_reg events in IDLE leave src_a, reg_led and state unchanged.
- Binary sequence: op_start (op_unary=0), then is_reg events carrying reg_num 2, 3, 1 -> src_a=2, src_b=3, dest=1, reg_led=4'b0111, state steps 1->2->3->4->0. sel_valid pulses once, 2 cycles after the third is_reg. Values hold afterwards.
- Unary sequence: op_start with op_unary=1, then events 4 and 4 -> src_a=4, src_b=0, dest=4, reg_led=4'b1000, GET_B skipped, sel_valid pulses once.
- Invalid and abort handling:
  - reg_num=0 during GET_A -> ignored, state stays 1.
  - cancel asserted in GET_B -> state 0, all latched outputs 0, no sel_valid.
  - op_start pulsed in GET_A -> ignored.
- Timeout (TIMEOUT=16 in the bench): op_start, event 1, then idle -> timeout pulses exactly 16 cycles after the FSM enters GET_B; state returns to 0 and outputs clear.
  - An event arriving at count 15 is accepted instead; no timeout.
- With REG_SELECTOR_DUP_REJECT_EN: events 3, 3, 2, 1 -> the second 3 pulses dup_err and is rejected; final src_a=3, src_b=2, dest=1.
- Without REG_SELECTOR_DUP_REJECT_EN: events 3, 3, 2 -> src_a=3, src_b=3, dest=2.

Source files
------------

// File: rtl/register_selector_if.sv
// Bundles the register-select event stream and operand/status outputs of register_selector.
// With REG_SELECTOR_DUP_REJECT_EN defined, the dup_err strobe is also carried.
interface register_selector_if;
    logic       is_reg;
    logic [2:0] reg_num;
    logic       op_start;
    logic       op_unary;
    logic       cancel;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dest;
    logic [3:0] reg_led;
    logic       busy;
    logic       sel_valid;
    logic       timeout;
    logic [2:0] state;
`ifdef REG_SELECTOR_DUP_REJECT_EN
    logic       dup_err;

    modport master (
        output is_reg, reg_num, op_start, op_unary, cancel,
        input  src_a, src_b, dest, reg_led, busy, sel_valid, timeout, state, dup_err
    );
    modport slave (
        input  is_reg, reg_num, op_start, op_unary, cancel,
        output src_a, src_b, dest, reg_led, busy, sel_valid, timeout, state, dup_err
    );
`else
    modport master (
        output is_reg, reg_num, op_start, op_unary, cancel,
        input  src_a, src_b, dest, reg_led, busy, sel_valid, timeout, state
    );
    modport slave (
        input  is_reg, reg_num, op_start, op_unary, cancel,
        output src_a, src_b, dest, reg_led, busy, sel_valid, timeout, state
    );
`endif
endinterface

// File: rtl/register_selector.sv
// Sequences operand selection (source A, optional source B, destination) from register-button events.
// Optional REG_SELECTOR_DUP_REJECT_EN rejects a source B equal to source A and pulses dup_err.
//
//   state  | meaning
//   IDLE   | waiting for op_start; button events ignored
//   GET_A  | waiting for source A selection
//   GET_B  | waiting for source B selection (skipped for unary ops)
//   GET_D  | waiting for destination selection
//   DONE   | one-cycle sel_valid strobe, then back to IDLE
module register_selector #(
    parameter int unsigned TIMEOUT = 1000000,
    parameter int unsigned TCNT_W  = 20
) (
    input logic                clk,
    input logic                nrst,
    register_selector_if.slave sel_if
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        GET_D = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              is_reg_d_q;
    logic              unary_q, unary_d;
    logic [2:0]        src_a_q, src_a_d;
    logic [2:0]        src_b_q, src_b_d;
    logic [2:0]        dest_q, dest_d;
    logic [3:0]        reg_led_q, reg_led_d;
    logic              sel_valid_q, sel_valid_d;
    logic              timeout_q, timeout_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              clear_sel;
    logic              ev_valid;
    logic [3:0]        ev_led;
`ifdef REG_SELECTOR_DUP_REJECT_EN
    logic              dup_err_q, dup_err_d;
`endif

    // reg_num trails the is_reg pulse by one cycle, so it is qualified by the delayed pulse
    assign ev_valid = is_reg_d_q && (sel_if.reg_num != 3'd0) && (sel_if.reg_num <= 3'd4);

    always_comb begin
        ev_led = 4'b0000;
        case (sel_if.reg_num)
            3'd1:    ev_led = 4'b0001;
            3'd2:    ev_led = 4'b0010;
            3'd3:    ev_led = 4'b0100;
            3'd4:    ev_led = 4'b1000;
            default: ev_led = 4'b0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        unary_d     = unary_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        dest_d      = dest_q;
        reg_led_d   = reg_led_q;
        sel_valid_d = 1'b0;
        timeout_d   = 1'b0;
        tcnt_d      = tcnt_q;
        clear_sel   = 1'b0;
`ifdef REG_SELECTOR_DUP_REJECT_EN
        dup_err_d   = 1'b0;
`endif
        if (sel_if.cancel) begin
            state_d   = IDLE;
            tcnt_d    = '0;
            clear_sel = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tcnt_d = '0;
                    if (sel_if.op_start) begin
                        state_d   = GET_A;
                        unary_d   = sel_if.op_unary;
                        clear_sel = 1'b1;
                    end
                end
                GET_A, GET_B, GET_D: begin
                    if (ev_valid) begin
                        tcnt_d = '0;
                        case (state_q)
                            GET_A: begin
                                src_a_d   = sel_if.reg_num;
                                reg_led_d = reg_led_q | ev_led;
                                state_d   = unary_q ? GET_D : GET_B;
                            end
                            GET_B: begin
`ifdef REG_SELECTOR_DUP_REJECT_EN
                                if (sel_if.reg_num == src_a_q)
                                    dup_err_d = 1'b1;
                                else
`endif
                                begin
                                    src_b_d   = sel_if.reg_num;
                                    reg_led_d = reg_led_q | ev_led;
                                    state_d   = GET_D;
                                end
                            end
                            default: begin
                                dest_d      = sel_if.reg_num;
                                reg_led_d   = reg_led_q | ev_led;
                                state_d     = DONE;
                                sel_valid_d = 1'b1;
                            end
                        endcase
                    end else if (tcnt_q == TCNT_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        tcnt_d    = '0;
                        clear_sel = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                // DONE and any illegal encoding fall back to IDLE
                default: begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end
            endcase
        end
        if (clear_sel) begin
            src_a_d   = 3'd0;
            src_b_d   = 3'd0;
            dest_d    = 3'd0;
            reg_led_d = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            is_reg_d_q  <= 1'b0;
            unary_q     <= 1'b0;
            src_a_q     <= 3'd0;
            src_b_q     <= 3'd0;
            dest_q      <= 3'd0;
            reg_led_q   <= 4'b0000;
            sel_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            tcnt_q      <= '0;
`ifdef REG_SELECTOR_DUP_REJECT_EN
            dup_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            is_reg_d_q  <= sel_if.is_reg;
            unary_q     <= unary_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dest_q      <= dest_d;
            reg_led_q   <= reg_led_d;
            sel_valid_q <= sel_valid_d;
            timeout_q   <= timeout_d;
            tcnt_q      <= tcnt_d;
`ifdef REG_SELECTOR_DUP_REJECT_EN
            dup_err_q   <= dup_err_d;
`endif
        end
    end

    assign sel_if.src_a     = src_a_q;
    assign sel_if.src_b     = src_b_q;
    assign sel_if.dest      = dest_q;
    assign sel_if.reg_led   = reg_led_q;
    assign sel_if.sel_valid = sel_valid_q;
    assign sel_if.timeout   = timeout_q;
    assign sel_if.state     = state_q;
    assign sel_if.busy      = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_D);
`ifdef REG_SELECTOR_DUP_REJECT_EN
    assign sel_if.dup_err   = dup_err_q;
`endif
endmodule

// File: tb/tb_register_selector.sv
// Scoreboard bench for register_selector (TIMEOUT=16): directed corner cases plus randomized operations.
module tb_register_selector;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    register_selector_if bus ();

    register_selector #(.TIMEOUT(16), .TCNT_W(5)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .sel_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit to;
        int a;
        int b;
        int d;
        int led;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int led_of(input int n);
        return (n >= 1 && n <= 4) ? (1 << (n - 1)) : 0;
    endfunction

    task automatic push_sel(input int a, input int b, input int d);
        exp_t e;
        e.to = 1'b0; e.a = a; e.b = b; e.d = d;
        e.led = led_of(a) | led_of(b) | led_of(d);
        sb.push_back(e);
    endtask

    task automatic push_to();
        exp_t e;
        e.to = 1'b1; e.a = 0; e.b = 0; e.d = 0; e.led = 0;
        sb.push_back(e);
    endtask

    // Monitor: every sel_valid/timeout strobe is matched against the next expected outcome
    always @(negedge clk) begin
        exp_t e;
        if (nrst && (bus.sel_valid || bus.timeout)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_kind_timeout", int'(bus.timeout), int'(e.to));
                check("sb_kind_sel_valid", int'(bus.sel_valid), int'(!e.to));
                check("sb_src_a", int'(bus.src_a), e.a);
                check("sb_src_b", int'(bus.src_b), e.b);
                check("sb_dest", int'(bus.dest), e.d);
                check("sb_reg_led", int'(bus.reg_led), e.led);
            end
        end
    end

    task automatic op_start(input bit u);
        @(posedge clk); #1;
        bus.op_start = 1'b1;
        bus.op_unary = u;
        @(posedge clk); #1;
        bus.op_start = 1'b0;
        bus.op_unary = 1'($urandom_range(0, 1));
    endtask

    task automatic send_event(input int n, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        bus.is_reg  = 1'b1;
        bus.reg_num = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        bus.is_reg  = 1'b0;
        bus.reg_num = 3'(n);
        @(posedge clk); #1;
        bus.reg_num = 3'($urandom_range(0, 7));
    endtask

    task automatic pulse_cancel();
        @(posedge clk); #1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  early;
        int  mode, need, got, stop_at, n;
        bit  u, ok, prev_bad;
        int  vals[3];

        bus.is_reg = 1'b0; bus.reg_num = 3'd0; bus.op_start = 1'b0;
        bus.op_unary = 1'b0; bus.cancel = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_state", int'(bus.state), 0);
        check("rst_outputs", int'({bus.src_a, bus.src_b, bus.dest, bus.reg_led}), 0);
        check("rst_strobes", int'({bus.busy, bus.sel_valid, bus.timeout}), 0);
        @(posedge clk); #1; nrst = 1'b1;

        // events in IDLE are ignored
        send_event(3, 0);
        send_event(2, 0);
        @(negedge clk);
        check("idle_ev_state", int'(bus.state), 0);
        check("idle_ev_src_a", int'(bus.src_a), 0);
        check("idle_ev_led", int'(bus.reg_led), 0);

        // binary sequence 2,3,1
        op_start(1'b0);
        @(negedge clk); check("bin_state_a", int'(bus.state), 1);
        check("bin_busy", int'(bus.busy), 1);
        send_event(2, 0);
        @(negedge clk); check("bin_state_b", int'(bus.state), 2);
        send_event(3, 1);
        @(negedge clk); check("bin_state_d", int'(bus.state), 3);
        push_sel(2, 3, 1);
        send_event(1, 0);
        @(negedge clk);
        check("bin_sel_valid_lat", int'(bus.sel_valid), 1);
        check("bin_state_done", int'(bus.state), 4);
        @(negedge clk);
        check("bin_state_idle", int'(bus.state), 0);
        check("bin_sel_valid_once", int'(bus.sel_valid), 0);
        repeat (3) @(negedge clk);
        check("bin_hold", int'({bus.src_a, bus.src_b, bus.dest, bus.reg_led}),
              int'({3'd2, 3'd3, 3'd1, 4'b0111}));

        // unary sequence 4,4
        op_start(1'b1);
        send_event(4, 0);
        @(negedge clk); check("un_skip_b", int'(bus.state), 3);
        push_sel(4, 0, 4);
        send_event(4, 0);
        repeat (3) @(posedge clk); #1;

        // reg_num 0 ignored, op_start in GET_A ignored
        op_start(1'b0);
        send_event(0, 0);
        @(negedge clk); check("inv_ev_state", int'(bus.state), 1);
        op_start(1'b1);
        @(negedge clk); check("opstart_in_get_a", int'(bus.state), 1);
        send_event(1, 0);
        send_event(2, 0);
        push_sel(1, 2, 3);
        send_event(3, 0);
        repeat (3) @(posedge clk); #1;

        // cancel in GET_B
        op_start(1'b0);
        send_event(4, 0);
        @(negedge clk); check("cancel_pre_state", int'(bus.state), 2);
        pulse_cancel();
        @(negedge clk);
        check("cancel_state", int'(bus.state), 0);
        check("cancel_outputs", int'({bus.src_a, bus.src_b, bus.dest, bus.reg_led}), 0);
        repeat (3) @(posedge clk); #1;

        // timeout exactly 16 cycles after entering GET_B
        op_start(1'b0);
        send_event(1, 0);
        push_to();
        early = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.timeout) early = 1;
        end
        check("to_not_early", early, 0);
        @(negedge clk);
        check("to_pulse", int'(bus.timeout), 1);
        check("to_state", int'(bus.state), 0);
        check("to_cleared", int'({bus.src_a, bus.reg_led}), 0);
        repeat (2) @(posedge clk); #1;

        // event sampled at count 15 wins over timeout
        op_start(1'b0);
        send_event(1, 0);
        send_event(2, 13);
        @(negedge clk);
        check("to_edge_state", int'(bus.state), 3);
        check("to_edge_src_b", int'(bus.src_b), 2);
        push_sel(1, 2, 4);
        send_event(4, 0);
        repeat (3) @(posedge clk); #1;

`ifdef REG_SELECTOR_DUP_REJECT_EN
        op_start(1'b0);
        send_event(3, 0);
        send_event(3, 0);
        @(negedge clk);
        check("dup_err_pulse", int'(bus.dup_err), 1);
        check("dup_state", int'(bus.state), 2);
        @(negedge clk);
        check("dup_err_once", int'(bus.dup_err), 0);
        send_event(2, 0);
        push_sel(3, 2, 1);
        send_event(1, 0);
`else
        op_start(1'b0);
        send_event(3, 0);
        send_event(3, 0);
        push_sel(3, 3, 2);
        send_event(2, 0);
`endif
        repeat (3) @(posedge clk); #1;

        // reset mid-sequence
        op_start(1'b0);
        send_event(2, 0);
        #2 nrst = 1'b0;
        @(negedge clk);
        check("midrst_state", int'(bus.state), 0);
        check("midrst_outputs", int'({bus.src_a, bus.reg_led, bus.busy}), 0);
        @(posedge clk); #1; nrst = 1'b1;

        // randomized operations
        for (int op = 0; op < 40; op++) begin
            mode     = $urandom_range(0, 3);
            u        = 1'($urandom_range(0, 1));
            need     = u ? 2 : 3;
            got      = 0;
            prev_bad = 1'b0;
            stop_at  = (mode < 2) ? $urandom_range(0, need - 1) : need;
            op_start(u);
            while (got < stop_at) begin
                n  = prev_bad ? $urandom_range(1, 4) : $urandom_range(0, 7);
                ok = (n >= 1 && n <= 4);
                prev_bad = !ok;
`ifdef REG_SELECTOR_DUP_REJECT_EN
                if (ok && !u && got == 1 && n == vals[0]) ok = 1'b0;
`endif
                if (ok) begin
                    vals[got] = n;
                    got++;
                    if (got == need) begin
                        if (u) push_sel(vals[0], 0, vals[1]);
                        else   push_sel(vals[0], vals[1], vals[2]);
                    end
                end
                send_event(n, $urandom_range(0, 2));
            end
            if (mode == 0) begin
                push_to();
                repeat (20) @(posedge clk); #1;
            end else if (mode == 1) begin
                pulse_cancel();
            end
            repeat (2) @(posedge clk); #1;
        end

        repeat (5) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
